// File: rtl/dm_frame_source.sv
// dm_frame_source: double-buffered 8x8 frame source with frame-aligned commit and timed row rotation.
module dm_frame_source #(
  parameter int FRAMES_PER_STEP = 25
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_fDone,
  input  logic        i_WrEn,
  input  logic [2:0]  i_WrAddr,
  input  logic [7:0]  i_WrData,
  input  logic        i_Commit,
  input  logic        i_ScrollEn,
  input  logic        i_ScrollDir,
  output logic [63:0] o_Data,
  output logic        o_Pending,
  output logic        o_StepTick
);
  typedef enum logic {IDLE, PENDING} state_t;
  localparam logic [7:0] LAST = 8'(FRAMES_PER_STEP - 1);
  state_t            state_q, state_d;
  logic [7:0][7:0]   back_q;
  logic [63:0]       data_q, data_d, rot;
  logic [7:0]        cnt_q, cnt_d;
  logic              tick_q, swap, step;
  for (genvar r = 0; r < 8; r++) begin : g_rot
    assign rot[8*r+:8] = i_ScrollDir ? {data_q[8*r], data_q[8*r+1+:7]}
                                     : {data_q[8*r+:7], data_q[8*r+7]};
  end
  // A swap at a frame boundary takes priority over a due scroll step.
  always_comb begin
    swap    = state_q == PENDING && i_fDone;
    step    = !swap && i_fDone && i_ScrollEn && cnt_q == LAST;
    state_d = swap ? IDLE : (i_Commit ? PENDING : state_q);
    data_d  = swap ? back_q : (step ? rot : data_q);
    cnt_d   = (swap || !i_ScrollEn || step) ? 8'd0 : (i_fDone ? cnt_q + 8'd1 : cnt_q);
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      back_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tick_q  <= step;
      if (i_WrEn) back_q[i_WrAddr] <= i_WrData;
    end
  end
  assign o_Data     = data_q;
  assign o_Pending  = state_q == PENDING;
  assign o_StepTick = tick_q;
endmodule
